// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared memory port.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req;
    logic [DATA_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;
    logic                  if_err;

    logic                  dm_req;
    logic                  dm_we;
    logic [DATA_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [1:0]            dm_size;
    logic                  dm_sign;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_done;
    logic                  dm_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            mem_size;
    logic                  mem_sign;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_done, if_err,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_size, dm_sign,
        output dm_rdata, dm_done, dm_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
        input  mem_rdata, mem_ready
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_done, if_err,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_size, dm_sign,
        input  dm_rdata, dm_done, dm_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with misalignment rejection and a bounded wait for memory.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [1:0]            state_q,    state_d;
    logic                  last_dm_q,  last_dm_d;
    logic                  win_dm_q,   win_dm_d;
    logic                  err_q,      err_d;
    logic [7:0]            cnt_q,      cnt_d;
    logic                  we_q,       we_d;
    logic [DATA_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [1:0]            size_q,     size_d;
    logic                  sign_q,     sign_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

    logic if_done, dm_done;
    logic if_req_m, dm_req_m;
    logic grant_dm;
    logic dm_misaligned;

    assign if_done = (state_q == StResp) && !win_dm_q;
    assign dm_done = (state_q == StResp) && win_dm_q;

    // A requester still seeing its done pulse must not be granted again off the same level.
    assign if_req_m = bus.if_req & ~if_done;
    assign dm_req_m = bus.dm_req & ~dm_done;
    assign grant_dm = dm_req_m & (~if_req_m | ~last_dm_q);

    assign dm_misaligned = ((bus.dm_size == 2'b01) && bus.dm_addr[0]) ||
                           (bus.dm_size[1] && (bus.dm_addr[1:0] != 2'b00));

    always_comb begin
        state_d    = state_q;
        last_dm_d  = last_dm_q;
        win_dm_d   = win_dm_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        sign_d     = sign_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            StIdle: begin
                if (if_req_m || dm_req_m) begin
                    last_dm_d = grant_dm;
                    win_dm_d  = grant_dm;
                    if (grant_dm && dm_misaligned) begin
                        state_d    = StResp;
                        err_d      = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        state_d = StBusy;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        we_d    = grant_dm & bus.dm_we;
                        addr_d  = grant_dm ? bus.dm_addr : bus.if_addr;
                        wdata_d = grant_dm ? bus.dm_wdata : '0;
                        size_d  = grant_dm ? bus.dm_size : 2'b10;
                        sign_d  = grant_dm & bus.dm_sign;
                    end
                end
            end
            StBusy: begin
                if (bus.mem_ready) begin
                    state_d = StResp;
                    if (win_dm_q) begin
                        dm_rdata_d = we_q ? '0 : bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    // Abort: the winner sees done+err with zeroed read data.
                    state_d = StResp;
                    err_d   = 1'b1;
                    if (win_dm_q) begin
                        dm_rdata_d = '0;
                    end else begin
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_dm_q  <= 1'b1;
            win_dm_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_dm_q  <= last_dm_d;
            win_dm_q   <= win_dm_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.mem_req   = (state_q == StBusy);
    assign bus.mem_we    = we_q & bus.mem_req;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_size  = size_q;
    assign bus.mem_sign  = sign_q;

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done;
    assign bus.if_err    = if_done & err_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_done   = dm_done;
    assign bus.dm_err    = dm_done & err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus random traffic checked every cycle
// against a transaction-level model of grant order, latency and returned data.
module tb_mem_port_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit in_reset = 1'b1;
    bit rand_mode = 1'b0;
    bit hold_mode = 1'b0;
    bit force_late = 1'b0;
    bit last_if_done, last_dm_done;

    // Model of the current/latest transaction, in absolute cycle numbers.
    int          m_next_idle, m_lo, m_hi, m_done;
    bit          m_who, m_err, m_last_dm, m_we, m_sign;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rd_exp;
    logic [31:0] m_rd [2];
    int          nxt_w, cur_w, hi_cnt;
    logic [31:0] nxt_data, cur_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int n;
        int l;
        bit rq_if, rq_dm, bad;
        n = cyc;
        if (n >= m_next_idle) begin
            rq_if = bus.if_req && !(m_done == n && !m_who);
            rq_dm = bus.dm_req && !(m_done == n && m_who);
            if (rq_if || rq_dm) begin
                m_who = (rq_if && rq_dm) ? !m_last_dm : rq_dm;
                m_last_dm = m_who;
                if (m_who) begin
                    m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
                    m_size = bus.dm_size; m_sign = bus.dm_sign;
                end else begin
                    m_we = 1'b0; m_addr = bus.if_addr; m_wdata = '0;
                    m_size = 2'b10; m_sign = 1'b0;
                end
                bad = m_who && ((m_size == 2'b01 && (m_addr % 2) != 0) ||
                                ((m_size == 2'b10 || m_size == 2'b11) && (m_addr % 4) != 0));
                if (bad) begin
                    l = 0; m_err = 1'b1; m_rd_exp = '0;
                end else if (nxt_w < int'(TO)) begin
                    l = nxt_w + 1; m_err = 1'b0; m_rd_exp = m_we ? 32'h0 : nxt_data;
                end else begin
                    l = TO; m_err = 1'b1; m_rd_exp = '0;
                end
                m_lo = n + 1; m_hi = n + l; m_done = n + l + 1; m_next_idle = n + l + 2;
                cur_w = nxt_w; cur_data = nxt_data;
                if (rand_mode) begin
                    nxt_w = $urandom_range(0, 5); nxt_data = $urandom;
                end
            end
        end
        cyc++;
        if (cyc == m_done) m_rd[m_who] = m_rd_exp;
    endtask

    task automatic mem_drive();
        if (bus.mem_req) begin
            hi_cnt++;
            bus.mem_ready = (hi_cnt == cur_w + 1);
            bus.mem_rdata = bus.mem_ready ? cur_data : $urandom;
        end else begin
            hi_cnt = 0;
            bus.mem_ready = rand_mode ? ($urandom_range(0, 3) == 0) : force_late;
            bus.mem_rdata = $urandom;
        end
    endtask

    task automatic new_dm();
        bus.dm_we = $urandom_range(0, 1);
        bus.dm_size = 2'($urandom_range(0, 3));
        bus.dm_sign = $urandom_range(0, 1);
        bus.dm_addr = $urandom;
        bus.dm_wdata = $urandom;
    endtask

    task automatic rand_req();
        bit busy_now;
        busy_now = (cyc >= m_lo) && (cyc <= m_done);
        if (last_if_done || !bus.if_req) begin
            bus.if_req = last_if_done ? $urandom_range(0, 1) : ($urandom_range(0, 2) == 0);
            if (bus.if_req) bus.if_addr = $urandom;
        end else if (busy_now && !m_who && $urandom_range(0, 3) == 0) begin
            bus.if_addr = $urandom;
        end
        if (last_dm_done || !bus.dm_req) begin
            bus.dm_req = last_dm_done ? $urandom_range(0, 1) : ($urandom_range(0, 2) == 0);
            if (bus.dm_req) new_dm();
        end else if (busy_now && m_who && $urandom_range(0, 3) == 0) begin
            new_dm();
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        mem_drive();
        if (rand_mode) begin
            rand_req();
        end else if (!hold_mode) begin
            if (last_if_done) bus.if_req = 1'b0;
            if (last_dm_done) bus.dm_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.mem_ready = 1'b0;
        #1;
        chk("rst_mem_req", bus.mem_req, 0);   chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0); chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_size", bus.mem_size, 0); chk("rst_mem_sign", bus.mem_sign, 0);
        chk("rst_if_done", bus.if_done, 0);   chk("rst_if_err", bus.if_err, 0);
        chk("rst_if_rdata", bus.if_rdata, 0); chk("rst_dm_done", bus.dm_done, 0);
        chk("rst_dm_err", bus.dm_err, 0);     chk("rst_dm_rdata", bus.dm_rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0; m_next_idle = 0; m_lo = 1; m_hi = 0; m_done = -1;
        m_last_dm = 1'b1; m_who = 1'b0; m_rd[0] = '0; m_rd[1] = '0; hi_cnt = 0;
        in_reset = 1'b0;
    endtask

    task automatic run_one(input bit is_dm, output int n_req, output int rel, output bit err,
                           output logic [31:0] rd, output logic [31:0] a_seen,
                           output logic [1:0] s_seen, output bit sg_seen);
        int start;
        start = cyc; n_req = 0; rel = -1; err = 1'b0; rd = '0;
        a_seen = '0; s_seen = '0; sg_seen = 1'b0;
        for (int i = 0; i < 40 && rel < 0; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                n_req++; a_seen = bus.mem_addr; s_seen = bus.mem_size; sg_seen = bus.mem_sign;
            end
            if (is_dm ? bus.dm_done : bus.if_done) begin
                rel = cyc - start;
                err = is_dm ? bus.dm_err : bus.if_err;
                rd = is_dm ? bus.dm_rdata : bus.if_rdata;
            end
            step();
        end
        chk("done_seen", rel >= 0, 1);
    endtask

    always @(negedge clk) begin : cmp
        bit eq, di, dd;
        if (!in_reset) begin
            eq = (cyc >= m_lo) && (cyc <= m_hi);
            di = (cyc == m_done) && !m_who;
            dd = (cyc == m_done) && m_who;
            chk("mem_req", bus.mem_req, eq);
            if (eq) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_we", bus.mem_we, m_we);
                chk("mem_size", bus.mem_size, m_size);
                chk("mem_sign", bus.mem_sign, m_sign);
                if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            chk("if_done", bus.if_done, di);
            chk("if_err", bus.if_err, di && m_err);
            chk("dm_done", bus.dm_done, dd);
            chk("dm_err", bus.dm_err, dd && m_err);
            chk("if_rdata", bus.if_rdata, m_rd[0]);
            chk("dm_rdata", bus.dm_rdata, m_rd[1]);
        end
        last_if_done = bus.if_done;
        last_dm_done = bus.dm_done;
    end

    initial begin
        int n_req, rel;
        bit err, sg;
        logic [31:0] rd, a;
        logic [1:0] s;
        int order [$];

        bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_size = '0; bus.dm_sign = 1'b0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        nxt_w = 0; nxt_data = '0; cur_w = 0; cur_data = '0;
        #2;
        do_reset();

        // Fetch with zero-wait memory.
        bus.if_req = 1'b1; bus.if_addr = 32'h100; nxt_w = 0; nxt_data = 32'h0050_0093;
        run_one(1'b0, n_req, rel, err, rd, a, s, sg);
        chk("t1_done_cycle", rel, 2);      chk("t1_rdata", rd, 32'h0050_0093);
        chk("t1_err", err, 0);             chk("t1_addr", a, 32'h100);
        chk("t1_size", s, 2'b10);          chk("t1_req_cycles", n_req, 1);

        // Misaligned sh and lw never reach memory.
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h203; bus.dm_size = 2'b01;
        bus.dm_wdata = 32'h1234_5678; bus.dm_sign = 1'b0;
        run_one(1'b1, n_req, rel, err, rd, a, s, sg);
        chk("t3_sh_done_cycle", rel, 1);   chk("t3_sh_err", err, 1);
        chk("t3_sh_rdata", rd, 0);         chk("t3_sh_req_cycles", n_req, 0);
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h202; bus.dm_size = 2'b10;
        run_one(1'b1, n_req, rel, err, rd, a, s, sg);
        chk("t3_lw_done_cycle", rel, 1);   chk("t3_lw_err", err, 1);
        chk("t3_lw_req_cycles", n_req, 0);

        // lbu with three wait states; ready lands on the last permitted cycle.
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h201; bus.dm_size = 2'b00;
        bus.dm_sign = 1'b0; nxt_w = 3; nxt_data = 32'h0000_00AB;
        run_one(1'b1, n_req, rel, err, rd, a, s, sg);
        chk("t4_req_cycles", n_req, 4);    chk("t4_rdata", rd, 32'hAB);
        chk("t4_err", err, 0);             chk("t4_size", s, 2'b00);
        chk("t4_sign", sg, 0);             chk("t4_done_cycle", rel, 5);

        // Memory never answers in time; stray mem_ready outside BUSY must be ignored.
        bus.if_req = 1'b1; bus.if_addr = 32'h400; nxt_w = 100; force_late = 1'b1;
        run_one(1'b0, n_req, rel, err, rd, a, s, sg);
        chk("t5_req_cycles", n_req, 4);    chk("t5_err", err, 1);
        chk("t5_rdata", rd, 0);            chk("t5_done_cycle", rel, 5);
        repeat (3) step();
        force_late = 1'b0;
        repeat (2) step();

        // Both requesters held from reset alternate, IF first.
        do_reset();
        hold_mode = 1'b1; nxt_w = 0; nxt_data = 32'hCAFE_0001;
        bus.if_req = 1'b1; bus.if_addr = 32'h800;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h900; bus.dm_size = 2'b10;
        repeat (20) begin
            @(negedge clk);
            if (bus.if_done) order.push_back(0);
            if (bus.dm_done) order.push_back(1);
            step();
        end
        hold_mode = 1'b0;
        repeat (12) step();
        chk("t2_grant_count", order.size() >= 4, 1);
        if (order.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t2_grant_order", order[i], i % 2);
        end

        // Reset while BUSY drops the transaction; a fresh fetch then completes.
        bus.if_req = 1'b1; bus.if_addr = 32'hC00; nxt_w = 3;
        repeat (2) step();
        #2;
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'hC04; nxt_w = 1; nxt_data = 32'hDEAD_BEEF;
        run_one(1'b0, n_req, rel, err, rd, a, s, sg);
        chk("t6_done_cycle", rel, 3);      chk("t6_rdata", rd, 32'hDEAD_BEEF);
        chk("t6_err", err, 0);             chk("t6_req_cycles", n_req, 2);

        // Random traffic against the model.
        rand_mode = 1'b1; nxt_w = $urandom_range(0, 5); nxt_data = $urandom;
        repeat (3000) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
